// File: rtl/v_shift_byte_packer_pkg.sv
// Shared constants, state encoding and shift-code decode for the byte packer
// and the shifter's checker.
package v_shift_pack_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = LANES * BYTE_W;
    localparam int SUM_W  = 4;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Shift code to shift amount: 00->0, 01->1, 10->3, 11->2.
    function automatic logic [1:0] shamt(input logic [1:0] sel);
        case (sel)
            2'b00:   shamt = 2'd0;
            2'b01:   shamt = 2'd1;
            2'b10:   shamt = 2'd3;
            default: shamt = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/v_shift_byte_packer_if.sv
// Byte-in / word-out handshake bundle of the packer. The slave modport is the
// packer itself; the master modport is the byte source plus word sink.
interface v_shift_byte_packer_if
    import v_shift_pack_pkg::*;
;
    logic [BYTE_W-1:0] DI;
    logic [1:0]        SEL;
    logic              DI_VALID;
    logic              LAST;
    logic              DI_READY;
    logic [WORD_W-1:0] DO;
    logic [LANES-1:0]  DO_KEEP;
    logic [SUM_W-1:0]  DO_SUM;
    logic              DO_VALID;
    logic              DO_READY;

    modport slave (
        input  DI, SEL, DI_VALID, LAST, DO_READY,
        output DI_READY, DO, DO_KEEP, DO_SUM, DO_VALID
    );

    modport master (
        output DI, SEL, DI_VALID, LAST, DO_READY,
        input  DI_READY, DO, DO_KEEP, DO_SUM, DO_VALID
    );

endinterface

// File: rtl/v_shift_byte_packer.sv
// Packs shifted bytes little-endian into 32-bit words with a lane-keep mask and
// the summed shift amount; one accumulator plus one output register.
module v_shift_byte_packer
    import v_shift_pack_pkg::*;
(
    input  logic                C,
    input  logic                RN,
    v_shift_byte_packer_if.slave bus
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d, do_q, do_d;
    logic [LANES-1:0]  keep_q, keep_d, do_keep_q, do_keep_d;
    logic [SUM_W-1:0]  sum_q, sum_d, do_sum_q, do_sum_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_valid_q, do_valid_d;

    logic [WORD_W-1:0] acc_nx;
    logic [LANES-1:0]  keep_nx;
    logic [SUM_W-1:0]  sum_nx;
    logic              accept, complete, slot_free;

    // Ready depends only on state and reset, never on DO_READY.
    assign bus.DI_READY = RN & (state_q == ACC);
    assign accept       = bus.DI_VALID & bus.DI_READY;
    assign slot_free    = ~do_valid_q | bus.DO_READY;
    assign complete     = accept & ((cnt_q == 2'd3) | bus.LAST);

    // Accumulator contents as they would be with the incoming byte merged in.
    always_comb begin
        acc_nx                            = acc_q;
        keep_nx                           = keep_q;
        acc_nx[{cnt_q, 3'b000} +: BYTE_W] = bus.DI;
        keep_nx[cnt_q]                    = 1'b1;
        sum_nx                            = sum_q + {2'b00, shamt(bus.SEL)};
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        keep_d     = keep_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        do_d       = do_q;
        do_keep_d  = do_keep_q;
        do_sum_d   = do_sum_q;
        do_valid_d = do_valid_q & ~bus.DO_READY;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (complete && slot_free) begin
                        do_d       = acc_nx;
                        do_keep_d  = keep_nx;
                        do_sum_d   = sum_nx;
                        do_valid_d = 1'b1;
                        acc_d      = '0;
                        keep_d     = '0;
                        sum_d      = '0;
                        cnt_d      = '0;
                    end else begin
                        acc_d  = acc_nx;
                        keep_d = keep_nx;
                        sum_d  = sum_nx;
                        cnt_d  = cnt_q + 2'd1;
                        if (complete) state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    do_d       = acc_q;
                    do_keep_d  = keep_q;
                    do_sum_d   = sum_q;
                    do_valid_d = 1'b1;
                    acc_d      = '0;
                    keep_d     = '0;
                    sum_d      = '0;
                    cnt_d      = '0;
                    state_d    = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge C) begin
        if (!RN) begin
            state_q    <= ACC;
            acc_q      <= '0;
            keep_q     <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            do_q       <= '0;
            do_keep_q  <= '0;
            do_sum_q   <= '0;
            do_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            keep_q     <= keep_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            do_q       <= do_d;
            do_keep_q  <= do_keep_d;
            do_sum_q   <= do_sum_d;
            do_valid_q <= do_valid_d;
        end
    end

    assign bus.DO       = do_q;
    assign bus.DO_KEEP  = do_keep_q;
    assign bus.DO_SUM   = do_sum_q;
    assign bus.DO_VALID = do_valid_q;

endmodule
